// File: rtl/ins_mem_loader.sv
`timescale 1ns/1ps
// Instruction-memory writer: turns a length-prefixed big-endian byte stream into word writes and holds the CPU until the image is in.
// Latency: a word is written the cycle after its 4th byte; LOAD_DONE rises the cycle after the final write. Backpressure: IN_READY low in IDLE/DONE and while LOAD_START is high.
module ins_mem_loader #(
    parameter int unsigned DEPTH    = 4001,
    parameter int unsigned ADR_STEP = 4,
    parameter int unsigned ADR_W    = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LOAD_START,
    input  logic             IN_VALID,
    input  logic [7:0]       IN_BYTE,
    output logic             IN_READY,
    output logic             MEM_WE,
    output logic [ADR_W-1:0] MEM_ADR,
    output logic [31:0]      MEM_WDATA,
    output logic             CPU_HOLD,
    output logic             LOAD_DONE,
    output logic             LOAD_ERR
);

    localparam int unsigned      MAX_WORDS  = (DEPTH - 1) / ADR_STEP + 1;
    localparam logic [ADR_W-1:0] ADR_STEP_W = ADR_W'(ADR_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [15:0]      word_cnt_q, word_cnt_d;
    logic [23:0]      asm_q, asm_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             in_rdy;
    logic             xfer;
    logic [15:0]      len_full;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        in_rdy     = 1'b0;
        len_full   = {len_q[15:8], IN_BYTE};

        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA, S_ERR: in_rdy = 1'b1;
            default:                           in_rdy = 1'b0;
        endcase
        // A restart blocks the stream for one cycle so no byte lands in the old load.
        if (LOAD_START) begin
            in_rdy = 1'b0;
        end
        xfer = IN_VALID && in_rdy;

        if (LOAD_START) begin
            state_d    = S_LEN_HI;
            len_d      = 16'd0;
            byte_cnt_d = 2'd0;
            word_cnt_d = 16'd0;
        end else begin
            case (state_q)
                S_LEN_HI: begin
                    if (xfer) begin
                        len_d[15:8] = IN_BYTE;
                        state_d     = S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_d = len_full;
                        if (len_full == 16'd0) begin
                            state_d = S_DONE;
                        end else if ({16'd0, len_full} > MAX_WORDS) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        asm_d      = {asm_q[15:0], IN_BYTE};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            we_d       = 1'b1;
                            wdata_d    = {asm_q, IN_BYTE};
                            adr_d      = ADR_W'(word_cnt_q) * ADR_STEP_W;
                            word_cnt_d = word_cnt_q + 16'd1;
                            // The final write issues from DONE, so DONE's flags trail it by one cycle.
                            if (word_cnt_q + 16'd1 == len_q) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end

        done_d = (state_q == S_DONE) && (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 16'd0;
            asm_q      <= 24'd0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            wdata_q    <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign IN_READY  = in_rdy;
    assign MEM_WE    = we_q;
    assign MEM_ADR   = adr_q;
    assign MEM_WDATA = wdata_q;
    assign CPU_HOLD  = !done_q;
    assign LOAD_DONE = done_q;
    assign LOAD_ERR  = err_q;

endmodule

// File: doc/ins_mem_loader.md
Name: ins_mem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads each cycle.
- Receives a program image as a byte stream with a valid/ready handshake.
- Assembles the bytes into 32-bit big-endian instruction words and issues one write per word, with word k written at address k*ADR_STEP, matching the fetch-stage PC stride.
- Holds the CPU (CPU_HOLD) from reset until a complete image has been written.

Parameters:
- DEPTH, 4001: number of instruction-memory entries (valid addresses 0..DEPTH-1).
- ADR_STEP, 4: address increment per word; equals the fetch-stage PC increment.
- ADR_W, 32: width of MEM_ADR.
- MAX_WORDS, derived = (DEPTH-1)/ADR_STEP + 1 (1001 at defaults): largest legal word count.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- LOAD_START  in  1  one-cycle pulse; begins or restarts a load.
- IN_VALID  in  1  IN_BYTE is valid.
- IN_BYTE  in  8  stream byte.
- IN_READY  out  1  loader accepts a byte this cycle.
- MEM_WE  out  1  instruction-memory write strobe, one cycle per word.
- MEM_ADR  out  ADR_W  write address (word index * ADR_STEP).
- MEM_WDATA  out  32  instruction word.
- CPU_HOLD  out  1  high = fetch/PC must not advance.
- LOAD_DONE  out  1  level, image fully written.
- LOAD_ERR  out  1  level, word count exceeded MAX_WORDS.

Behaviour:
- Byte transfer: a byte transfers on a rising edge where IN_VALID && IN_READY. IN_VALID may assert without waiting for IN_READY.
- Stream format: 16-bit word count N (high byte first), then N words, each MSB byte first.
- Reset (RST_N low, asynchronous): state IDLE, IN_READY=0, MEM_WE=0, MEM_ADR=0, MEM_WDATA=0, CPU_HOLD=1, LOAD_DONE=0, LOAD_ERR=0, all counters 0.
- State IDLE: IN_READY=0. LOAD_START -> LEN_HI.
- State LEN_HI: IN_READY=1. On transfer, latch N[15:8] -> LEN_LO.
- State LEN_LO: IN_READY=1. On transfer, latch N[7:0], then:
  - N==0 -> DONE.
  - N>MAX_WORDS -> ERR.
  - otherwise -> DATA.
- State DATA: IN_READY=1.
  - A 2-bit byte counter shifts bytes into a 32-bit assembly register, MSB first.
  - On the 4th byte transfer, the next cycle drives MEM_WE=1, MEM_WDATA=assembled word, MEM_ADR=k*ADR_STEP; then k increments and the byte counter wraps to 0.
  - A write of word k and acceptance of the first byte of word k+1 may occur in the same cycle. Full throughput is one byte per cycle, no bubbles.
  - After the write of word N-1 -> DONE (the write cycle itself is still in DATA or the transition cycle; no write is lost).
- State DONE: IN_READY=0, LOAD_DONE=1, CPU_HOLD=0 starting the cycle after the final MEM_WE. Stays until LOAD_START.
- State ERR: LOAD_ERR=1, CPU_HOLD=1, IN_READY=1. Bytes are accepted and discarded so the upstream does not deadlock; no MEM_WE is issued. Leaves only on LOAD_START.
- MEM_WE timing: exactly one cycle wide. MEM_ADR and MEM_WDATA are valid whenever MEM_WE=1 and hold their last value otherwise.
- LOAD_START in any state, including mid-word:
  - IN_READY is forced to 0 combinationally that cycle, so no byte transfers.
  - Next state is LEN_HI; byte and word counters are cleared; the partial word is discarded.
  - CPU_HOLD=1, LOAD_DONE=0, LOAD_ERR=0.
  - A MEM_WE already scheduled for that cycle still completes.
- Asynchronous reset mid-load: the load is abandoned immediately; words already written stay in memory; CPU_HOLD returns to 1.
- Widths: word counter is 16 bits. MEM_ADR = k*ADR_STEP, computed in ADR_W bits, with no wrap for legal N.

Test Plan:
- Reset then LOAD_START, stream 00 02 20 09 00 02 00 00 00 00 with IN_VALID always high:
  - MEM_WE at address 0 with data 0x20090002, then address 4 with 0x00000000, on consecutive words 4 cycles apart.
  - LOAD_DONE=1 and CPU_HOLD=0 the cycle after the second write.
- Same image with IN_VALID toggling every other cycle: identical writes and data. No byte is lost or duplicated, and IN_READY is held when IN_VALID=0.
- Stream 00 00: no MEM_WE; LOAD_DONE=1 and CPU_HOLD=0 two cycles after the second transfer.
- Stream 03 EA (N=1002 > 1001): LOAD_ERR=1, CPU_HOLD=1. The following 8 bytes are accepted with no MEM_WE. LOAD_START clears LOAD_ERR.
- LOAD_START after 2 bytes of word 1, then a fresh image 00 01 DE AD BE EF: the single write is 0xDEADBEEF at address 0, and the partial word never appears on MEM_WDATA.
- RST_N pulsed low asynchronously mid-word (not clock-aligned): all outputs return to reset values immediately; there is no MEM_WE until a new LOAD_START.
